jtype_redirect_ctrl: RTL and testbench

Registered J-type control and redirect unit for the processor's decode/execute boundary. Decodes the J-type opcodes (`j`, `jal`, `bex`, `setx`, and optionally `jr`), resolves each one a cycle later into a fetch redirect and/or a register write-back, and squashes younger in-flight slots with a parametrised flush window. It generalises the purely combinational J-type classifier into a pipelined, stall-aware block with a flush FSM.

---
 rtl/jtype_redirect_ctrl.sv | 229 ++++++++++++++++++++++
 tb/tb_jtype_redirect_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtype_redirect_ctrl.sv
// ============================================================================
// jtype_redirect_ctrl
// ----------------------------------------------------------------------------
// Registered J-type control and redirect unit at the decode/execute boundary.
// It decodes j, jal, bex, setx (and jr when enabled). One cycle after an
// instruction is accepted, it produces a fetch redirect and/or a register
// write-back. After any taken redirect, a small FSM holds `flush` high so that
// the younger in-flight slots are squashed.
//
// Optional feature macro: JTYPE_JR_EN
//   defined   -> opcode 5'b00100 decodes as jr (redirect to in_rd_val, flush)
//   undefined -> opcode 5'b00100 is treated as a non-J instruction
//
// Parameters:
//   PC_W        program-counter / register data width (>= 27)
//   TGT_W       immediate target field width (<= PC_W)
//   FLUSH_DEPTH younger slots squashed after a taken redirect (1..7)
//
// Ports:
//   clock          rising-edge clock
//   reset_n        asynchronous active-low reset
//   stall          pipeline hold; nothing is accepted or advanced while high
//   in_valid       decode slot holds a real instruction
//   in_opcode      5-bit opcode
//   in_target      immediate T field
//   in_pc          PC of the decode-slot instruction
//   in_rd_val      $rd read value (jr target)
//   in_rstatus     current $r30 value (bex condition)
//   jitype         registered pulse: accepted instruction was J-type
//   redirect_valid one-cycle pulse: fetch must load redirect_pc
//   redirect_pc    redirect target; holds between pulses
//   flush          high while younger slots are being squashed
//   wb_we          one-cycle register write strobe
//   wb_addr        write register (31 for jal, 30 for setx); holds
//   wb_data        write data; holds
// ============================================================================
module jtype_redirect_ctrl #(
  parameter int PC_W        = 32,
  parameter int TGT_W       = 27,
  parameter int FLUSH_DEPTH = 2
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             stall,
  input  logic             in_valid,
  input  logic [4:0]       in_opcode,
  input  logic [TGT_W-1:0] in_target,
  input  logic [PC_W-1:0]  in_pc,
  input  logic [PC_W-1:0]  in_rd_val,
  input  logic [PC_W-1:0]  in_rstatus,
  output logic             jitype,
  output logic             redirect_valid,
  output logic [PC_W-1:0]  redirect_pc,
  output logic             flush,
  output logic             wb_we,
  output logic [4:0]       wb_addr,
  output logic [PC_W-1:0]  wb_data
);

  localparam logic [4:0] OP_J    = 5'b00001;
  localparam logic [4:0] OP_JAL  = 5'b00011;
  localparam logic [4:0] OP_BEX  = 5'b10110;
  localparam logic [4:0] OP_SETX = 5'b10101;
  localparam logic [4:0] OP_JR   = 5'b00100;

  localparam logic [4:0] REG_RA     = 5'd31;
  localparam logic [4:0] REG_STATUS = 5'd30;

  // Three bits covers the full 1..7 flush window.
  localparam int         CNT_W      = 3;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FLUSH_DEPTH);

`ifdef JTYPE_JR_EN
  localparam bit JR_EN = 1'b1;
`else
  localparam bit JR_EN = 1'b0;
`endif

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  logic             accept;
  logic [PC_W-1:0]  tgt_ext;
  logic             is_jtype;
  logic             taken;
  logic             wr_en;
  logic [4:0]       wr_addr;
  logic [PC_W-1:0]  wr_data;
  logic [PC_W-1:0]  redir_target;

  // New instructions are only taken from the decode slot while idle.
  // Anything presented during a flush window is a squashed younger slot.
  assign accept = in_valid & ~stall & (state_q == ST_IDLE);

  // Zero-extend the immediate target. This is written as a partial
  // overwrite so that it still works when TGT_W == PC_W.
  always_comb begin
    tgt_ext              = '0;
    tgt_ext[TGT_W-1:0]   = in_target;
  end

  // Decode of the decode-slot instruction into its resolution: whether it is
  // J-type, whether it redirects fetch, and what (if anything) it writes.
  // bex only redirects when $r30 is non-zero. The jr target comes from the
  // register file rather than from the immediate.
  always_comb begin
    is_jtype     = 1'b0;
    taken        = 1'b0;
    wr_en        = 1'b0;
    wr_addr      = '0;
    wr_data      = '0;
    redir_target = tgt_ext;
    case (in_opcode)
      OP_J: begin
        is_jtype = 1'b1;
        taken    = 1'b1;
      end
      OP_JAL: begin
        is_jtype = 1'b1;
        taken    = 1'b1;
        wr_en    = 1'b1;
        wr_addr  = REG_RA;
        wr_data  = in_pc + PC_W'(1);
      end
      OP_BEX: begin
        is_jtype = 1'b1;
        taken    = (in_rstatus != '0);
      end
      OP_SETX: begin
        is_jtype = 1'b1;
        wr_en    = 1'b1;
        wr_addr  = REG_STATUS;
        wr_data  = tgt_ext;
      end
      OP_JR: begin
        if (JR_EN) begin
          is_jtype     = 1'b1;
          taken        = 1'b1;
          redir_target = in_rd_val;
        end
      end
      default: begin
      end
    endcase
  end

  // Flush FSM state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Flush FSM next-state logic. A taken redirect opens a window of
  // FLUSH_DEPTH non-stalled cycles. Stalled cycles do not consume the
  // window, because the younger slots have not moved while stalled.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (accept && taken) begin
          state_d = ST_FLUSH;
          cnt_d   = CNT_LOAD;
        end
      end
      ST_FLUSH: begin
        if (!stall) begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Flush FSM outputs. flush is decoded straight from the state register,
  // so an asynchronous reset drops it immediately.
  always_comb begin
    flush = 1'b0;
    if (state_q == ST_FLUSH) begin
      flush = 1'b1;
    end
  end

  // Resolution registers. The strobes are single-cycle pulses that follow
  // an accept. The target and write-back fields only update when their
  // strobe fires, so they keep the last value between pulses. A stall in
  // the resolution cycle does not cancel a pulse that is already
  // registered; it only prevents a new accept.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      jitype         <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      wb_we          <= 1'b0;
      wb_addr        <= '0;
      wb_data        <= '0;
    end else begin
      jitype         <= accept & is_jtype;
      redirect_valid <= accept & taken;
      wb_we          <= accept & wr_en;
      if (accept && taken) begin
        redirect_pc <= redir_target;
      end
      if (accept && wr_en) begin
        wb_addr <= wr_addr;
        wb_data <= wr_data;
      end
    end
  end

endmodule

// File: tb/tb_jtype_redirect_ctrl.sv
// ============================================================================
// tb_jtype_redirect_ctrl
// ----------------------------------------------------------------------------
// Self-checking bench for jtype_redirect_ctrl. It uses a vector table with
// expected pulse values, hand-written multi-cycle sequences (back-to-back
// issue, squashing during a flush, stalls inside the flush window, reset
// during a flush), and a randomized run. Every cycle is compared against a
// behavioural model that tracks the flush window as a plain cycle count.
// ============================================================================
module tb_jtype_redirect_ctrl;

  localparam int PC_W  = 32;
  localparam int TGT_W = 27;
  localparam int DEPTH = 2;

  localparam logic [4:0] OP_J    = 5'b00001;
  localparam logic [4:0] OP_JAL  = 5'b00011;
  localparam logic [4:0] OP_BEX  = 5'b10110;
  localparam logic [4:0] OP_SETX = 5'b10101;
  localparam logic [4:0] OP_JR   = 5'b00100;

  logic             clock = 1'b0;
  logic             reset_n;
  logic             stall;
  logic             in_valid;
  logic [4:0]       in_opcode;
  logic [TGT_W-1:0] in_target;
  logic [PC_W-1:0]  in_pc;
  logic [PC_W-1:0]  in_rd_val;
  logic [PC_W-1:0]  in_rstatus;
  logic             jitype;
  logic             redirect_valid;
  logic [PC_W-1:0]  redirect_pc;
  logic             flush;
  logic             wb_we;
  logic [4:0]       wb_addr;
  logic [PC_W-1:0]  wb_data;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  int          m_flush_left;
  logic        m_jitype;
  logic        m_rv;
  logic [31:0] m_rpc;
  logic        m_we;
  logic [4:0]  m_addr;
  logic [31:0] m_data;

  typedef struct {
    logic [4:0]  op;
    logic [26:0] tgt;
    logic [31:0] pc;
    logic [31:0] rd;
    logic [31:0] rs;
    logic        e_jit;
    logic        e_rv;
    logic [31:0] e_rpc;
    logic        e_we;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    int          e_flush;
  } vec_t;

  localparam int NVEC = 9;
  vec_t vecs[NVEC];

  always #5 clock = ~clock;

  jtype_redirect_ctrl #(
    .PC_W(PC_W),
    .TGT_W(TGT_W),
    .FLUSH_DEPTH(DEPTH)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .stall(stall),
    .in_valid(in_valid),
    .in_opcode(in_opcode),
    .in_target(in_target),
    .in_pc(in_pc),
    .in_rd_val(in_rd_val),
    .in_rstatus(in_rstatus),
    .jitype(jitype),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .flush(flush),
    .wb_we(wb_we),
    .wb_addr(wb_addr),
    .wb_data(wb_data)
  );

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic modelReset();
    m_flush_left = 0;
    m_jitype     = 1'b0;
    m_rv         = 1'b0;
    m_rpc        = '0;
    m_we         = 1'b0;
    m_addr       = '0;
    m_data       = '0;
  endtask

  // One clock edge of the reference behaviour, computed from the current inputs.
  task automatic modelStep();
    logic acc;
    acc = in_valid && !stall && (m_flush_left == 0);
    if (m_flush_left > 0 && !stall) m_flush_left--;
    m_jitype = 1'b0;
    m_rv     = 1'b0;
    m_we     = 1'b0;
    if (acc) begin
      case (in_opcode)
        OP_J: begin
          m_jitype = 1'b1; m_rv = 1'b1; m_rpc = 32'(in_target);
        end
        OP_JAL: begin
          m_jitype = 1'b1; m_rv = 1'b1; m_rpc = 32'(in_target);
          m_we = 1'b1; m_addr = 5'd31; m_data = in_pc + 32'd1;
        end
        OP_BEX: begin
          m_jitype = 1'b1;
          if (in_rstatus != 0) begin
            m_rv = 1'b1; m_rpc = 32'(in_target);
          end
        end
        OP_SETX: begin
          m_jitype = 1'b1; m_we = 1'b1; m_addr = 5'd30; m_data = 32'(in_target);
        end
`ifdef JTYPE_JR_EN
        OP_JR: begin
          m_jitype = 1'b1; m_rv = 1'b1; m_rpc = in_rd_val;
        end
`endif
        default: begin
        end
      endcase
      if (m_rv) m_flush_left = DEPTH;
    end
  endtask

  // Drive one cycle of inputs (we are at a falling edge), let the rising
  // edge happen, update the model, then return at the next falling edge.
  task automatic applyStimulus(input logic v, input logic s, input logic [4:0] op,
                               input logic [26:0] tgt, input logic [31:0] pc,
                               input logic [31:0] rd, input logic [31:0] rs);
    in_valid   = v;
    stall      = s;
    in_opcode  = op;
    in_target  = tgt;
    in_pc      = pc;
    in_rd_val  = rd;
    in_rstatus = rs;
    @(posedge clock);
    modelStep();
    @(negedge clock);
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 1'b0, 5'd0, 27'd0, 32'd0, 32'd0, 32'd0);
  endtask

  task automatic checkOutput(input string tag);
    checkVal({tag, ".jitype"},         32'(jitype),         32'(m_jitype));
    checkVal({tag, ".redirect_valid"}, 32'(redirect_valid), 32'(m_rv));
    checkVal({tag, ".redirect_pc"},    redirect_pc,         m_rpc);
    checkVal({tag, ".flush"},          32'(flush),          32'(m_flush_left > 0));
    checkVal({tag, ".wb_we"},          32'(wb_we),          32'(m_we));
    checkVal({tag, ".wb_addr"},        32'(wb_addr),        32'(m_addr));
    checkVal({tag, ".wb_data"},        wb_data,             m_data);
  endtask

  initial begin
    int hi_cnt;

    // Vector table: inputs followed by the expected pulse-cycle outputs.
    vecs[0] = '{OP_J,    27'h0000123, 32'h40,       32'h0,   32'h0, 1'b1, 1'b1, 32'h123,      1'b0, 5'd0,  32'h0,      DEPTH};
    vecs[1] = '{OP_JAL,  27'h0000200, 32'hFFFFFFFF, 32'h0,   32'h0, 1'b1, 1'b1, 32'h200,      1'b1, 5'd31, 32'h0,      DEPTH};
    vecs[2] = '{OP_BEX,  27'h0000055, 32'h80,       32'h0,   32'h0, 1'b1, 1'b0, 32'h0,        1'b0, 5'd0,  32'h0,      0};
    vecs[3] = '{OP_BEX,  27'h0000055, 32'h81,       32'h0,   32'h5, 1'b1, 1'b1, 32'h55,       1'b0, 5'd0,  32'h0,      DEPTH};
    vecs[4] = '{OP_SETX, 27'h0000007, 32'h90,       32'h0,   32'h0, 1'b1, 1'b0, 32'h0,        1'b1, 5'd30, 32'h7,      0};
    vecs[5] = '{OP_JAL,  27'h7FFFFFF, 32'h1000,     32'h0,   32'h0, 1'b1, 1'b1, 32'h07FFFFFF, 1'b1, 5'd31, 32'h1001,   DEPTH};
    vecs[6] = '{5'b00000, 27'h0000321, 32'hA0,      32'h0,   32'h9, 1'b0, 1'b0, 32'h0,        1'b0, 5'd0,  32'h0,      0};
    vecs[7] = '{5'b00010, 27'h0000321, 32'hA4,      32'h0,   32'h9, 1'b0, 1'b0, 32'h0,        1'b0, 5'd0,  32'h0,      0};
`ifdef JTYPE_JR_EN
    vecs[8] = '{OP_JR,   27'h0000011, 32'hB0,       32'hABC, 32'h0, 1'b1, 1'b1, 32'hABC,      1'b0, 5'd0,  32'h0,      DEPTH};
`else
    vecs[8] = '{OP_JR,   27'h0000011, 32'hB0,       32'hABC, 32'h0, 1'b0, 1'b0, 32'h0,        1'b0, 5'd0,  32'h0,      0};
`endif

    // Reset state
    reset_n    = 1'b0;
    stall      = 1'b0;
    in_valid   = 1'b0;
    in_opcode  = '0;
    in_target  = '0;
    in_pc      = '0;
    in_rd_val  = '0;
    in_rstatus = '0;
    modelReset();
    repeat (2) @(negedge clock);
    checkOutput("reset");
    reset_n = 1'b1;
    idleCycle();

    // Table-driven vectors
    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(1'b1, 1'b0, vecs[i].op, vecs[i].tgt, vecs[i].pc, vecs[i].rd, vecs[i].rs);
      checkVal($sformatf("tbl%0d.jitype", i), 32'(jitype), 32'(vecs[i].e_jit));
      checkVal($sformatf("tbl%0d.redirect_valid", i), 32'(redirect_valid), 32'(vecs[i].e_rv));
      checkVal($sformatf("tbl%0d.wb_we", i), 32'(wb_we), 32'(vecs[i].e_we));
      checkVal($sformatf("tbl%0d.flush", i), 32'(flush), 32'(vecs[i].e_flush > 0));
      if (vecs[i].e_rv) checkVal($sformatf("tbl%0d.redirect_pc", i), redirect_pc, vecs[i].e_rpc);
      if (vecs[i].e_we) begin
        checkVal($sformatf("tbl%0d.wb_addr", i), 32'(wb_addr), 32'(vecs[i].e_addr));
        checkVal($sformatf("tbl%0d.wb_data", i), wb_data, vecs[i].e_data);
      end
      checkOutput($sformatf("tbl%0d.model", i));
      for (int k = 1; k < vecs[i].e_flush; k++) begin
        idleCycle();
        checkVal($sformatf("tbl%0d.flush_hold", i), 32'(flush), 32'd1);
        checkVal($sformatf("tbl%0d.rv_single", i), 32'(redirect_valid), 32'd0);
      end
      idleCycle();
      checkVal($sformatf("tbl%0d.flush_end", i), 32'(flush), 32'd0);
      checkVal($sformatf("tbl%0d.rv_end", i), 32'(redirect_valid), 32'd0);
      checkOutput($sformatf("tbl%0d.after", i));
    end

    // setx, untaken bex back-to-back with j, then a j squashed during the flush
    applyStimulus(1'b1, 1'b0, OP_SETX, 27'h7, 32'h100, 32'h0, 32'h0);
    checkVal("seq.setx_data", wb_data, 32'h7);
    applyStimulus(1'b1, 1'b0, OP_BEX, 27'h44, 32'h101, 32'h0, 32'h0);
    checkVal("seq.bex0_jitype", 32'(jitype), 32'd1);
    checkVal("seq.bex0_flush", 32'(flush), 32'd0);
    applyStimulus(1'b1, 1'b0, OP_J, 27'h99, 32'h102, 32'h0, 32'h0);
    checkVal("seq.b2b_rv", 32'(redirect_valid), 32'd1);
    checkVal("seq.b2b_rpc", redirect_pc, 32'h99);
    checkVal("seq.wb_hold", wb_data, 32'h7);
    checkOutput("seq.b2b");
    applyStimulus(1'b1, 1'b0, OP_J, 27'h77, 32'h103, 32'h0, 32'h0);
    checkVal("seq.squash_rv", 32'(redirect_valid), 32'd0);
    checkVal("seq.squash_jitype", 32'(jitype), 32'd0);
    checkOutput("seq.squash");
    idleCycle();
    checkVal("seq.rpc_hold", redirect_pc, 32'h99);
    checkOutput("seq.end");

    // Taken j with stall held for 3 cycles inside the flush window
    applyStimulus(1'b1, 1'b0, OP_J, 27'h321, 32'h200, 32'h0, 32'h0);
    hi_cnt = flush ? 1 : 0;
    in_valid = 1'b0;
    stall    = 1'b1;
    #1;
    checkVal("stall.pulse_kept", 32'(redirect_valid), 32'd1);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, (i < 3), 5'd0, 27'd0, 32'd0, 32'd0, 32'd0);
      if (flush) hi_cnt++;
      checkOutput("stall.win");
    end
    checkVal("stall.flush_len", 32'(hi_cnt), 32'd5);

    // Reset asserted in the middle of a flush
    applyStimulus(1'b1, 1'b0, OP_J, 27'h456, 32'h300, 32'h0, 32'h0);
    in_valid = 1'b0;
    #1 reset_n = 1'b0;
    #1;
    checkVal("rst.flush", 32'(flush), 32'd0);
    checkVal("rst.redirect_valid", 32'(redirect_valid), 32'd0);
    checkVal("rst.redirect_pc", redirect_pc, 32'd0);
    modelReset();
    #1 reset_n = 1'b1;
    @(negedge clock);
    checkOutput("rst.after");

    // Randomized run checked against the model every cycle
    for (int i = 0; i < 400; i++) begin
      logic        v, s;
      logic [4:0]  op;
      logic [31:0] pc, rs;
      v = ($urandom_range(0, 9) < 7);
      s = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 7))
        0: op = OP_J;
        1: op = OP_JAL;
        2: op = OP_BEX;
        3: op = OP_SETX;
        4: op = OP_JR;
        5: op = OP_BEX;
        6: op = 5'b00000;
        default: op = 5'($urandom);
      endcase
      pc = ($urandom_range(0, 9) == 0) ? 32'hFFFFFFFF : $urandom;
      rs = ($urandom_range(0, 1) == 0) ? 32'h0 : $urandom;
      applyStimulus(v, s, op, 27'($urandom), pc, $urandom, rs);
      checkOutput("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
